button_debounce: RTL

Synchronises a raw mechanical push-button input into the `clk_in` domain and debounces it on a slow sample tick derived from `clk_in`. Produces a clean level plus single-cycle press, release and long-press events. Sits between board button pins and the control logic that the divided-clock blocks drive. It is the consumer end of the sample-rate path: it derives its own sample tick rather than running on a divided clock.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/tick_gen.sv | 29 ++
 rtl/button_debounce.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer and its tick generator.
package btn_pkg;

    // Debounce FSM states; encodings are fixed so waveforms stay readable.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_SAMPLE_DIV = 50000;
    localparam int unsigned DEF_STABLE_CNT = 20;
    localparam int unsigned DEF_LONG_CNT   = 1000;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running sample-tick generator: one-cycle tick every SAMPLE_DIV clocks.
module tick_gen
    import btn_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned      CW   = cnt_width(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]    LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the terminal count, then wrap to zero.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider count register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button synchroniser + debouncer with press/release/long-press pulses.
// Optional feature macro: BTN_LONG_PRESS_EN (long-press counter and btn_long).
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
    parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    if (SAMPLE_DIV < 2) begin : g_chk_div
        $error("button_debounce: SAMPLE_DIV must be >= 2");
    end
    if (STABLE_CNT < 1) begin : g_chk_stable
        $error("button_debounce: STABLE_CNT must be >= 1");
    end
    if (LONG_CNT < 1) begin : g_chk_long
        $error("button_debounce: LONG_CNT must be >= 1");
    end

    localparam logic             RELEASED_PIN = ACTIVE_LOW;
    localparam int unsigned      SCW          = cnt_width(STABLE_CNT);
    localparam logic [SCW-1:0]   STABLE_V     = SCW'(STABLE_CNT);
    localparam logic [SCW-1:0]   ONE_S        = SCW'(1);

    logic [1:0]     sync_q, sync_d;
    logic           btn_s;
    logic           tick;
    btn_state_t     state_q, state_d;
    logic [SCW-1:0] cnt_q, cnt_d, cnt_inc;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic           press_ok, release_ok;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned      HCW    = cnt_width(LONG_CNT);
    localparam logic [HCW-1:0]   LONG_V = HCW'(LONG_CNT);

    logic [HCW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic           long_q, long_d;
`endif

    tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick_gen (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchroniser; btn_s is 1 while pressed regardless of pin polarity.
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
        btn_s  = sync_q[1] ^ ACTIVE_LOW;
    end

    // Debounce FSM: next state, counters and event pulses, evaluated on ticks only.
    // With STABLE_CNT=1 the first agreeing sample is accepted directly from
    // IDLE/HELD, skipping the CHK state within the same tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + ONE_S;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        press_ok   = 1'b0;
        release_ok = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_d = hold_cnt_q;
        hold_inc   = hold_cnt_q + HCW'(1);
        long_d     = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_s) begin
                        if (STABLE_V == ONE_S) begin
                            press_ok = 1'b1;
                        end else begin
                            state_d = ST_PRESS_CHK;
                            cnt_d   = ONE_S;
                        end
                    end
                end
                ST_PRESS_CHK: begin
                    if (!btn_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == STABLE_V) begin
                        press_ok = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!btn_s) begin
                        if (STABLE_V == ONE_S) begin
                            release_ok = 1'b1;
                        end else begin
                            state_d = ST_RELEASE_CHK;
                            cnt_d   = ONE_S;
                        end
                    end
`ifdef BTN_LONG_PRESS_EN
                    else if (hold_cnt_q != LONG_V) begin
                        hold_cnt_d = hold_inc;
                        long_d     = (hold_inc == LONG_V);
                    end
`endif
                end
                ST_RELEASE_CHK: begin
                    if (btn_s) begin
                        // Back to HELD with hold count kept: a bounce cannot re-arm btn_long.
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == STABLE_V) begin
                        release_ok = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (press_ok) begin
            state_d = ST_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
        end
        if (release_ok) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State, counter, synchroniser and registered-output flops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {2{RELEASED_PIN}};
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
`ifdef BTN_LONG_PRESS_EN
    assign btn_long    = long_q;
`else
    assign btn_long    = 1'b0;
`endif

endmodule
